draw_triangle_pipe: RTL
=======================

// Module: draw_triangle_pipe
// PURPOSE
//  Downstream stage of the mesh controller: on start, walks the MVP result buffer (screen-space vertices),
//  assembles triangles (strip or list topology), fetches a per-triangle colour and hands each triangle to
//  draw_triangle via a draw_en/draw_done handshake. Asserts done once every triangle has been rasterised.
// PARAMETERS
//  WIDTH         32  bit width of vertex coordinates, count and memory data words
//  COLOUR_WIDTH  3   bit width of colour words
//  ADDR_WIDTH    8   bit width of mem_read_addr / mem_col_addr
// PORTS
//  clock          in   1             system clock, all logic on posedge
//  reset          in   1             synchronous, active-low reset
//  start          in   1             begin a run; sampled only while done=1
//  strip          in   1             1=triangle strip, 0=triangle list; latched at start
//  count          in   WIDTH         number of triangles to draw; latched at start
//  done           out  1             1 when idle (run complete or never started)
//  mem_read_addr  out  ADDR_WIDTH    vertex buffer word address
//  mem_read_data  in   WIDTH         vertex word, valid 1 cycle after address (sync RAM)
//  mem_col_addr   out  ADDR_WIDTH    colour buffer address (= triangle index)
//  mem_col_data   in   COLOUR_WIDTH  colour, valid 1 cycle after address
//  ax,ay,az bx,by,bz cx,cy,cz  out  WIDTH each  triangle vertices to rasteriser
//  colour         out  COLOUR_WIDTH  triangle colour
//  draw_en        out  1             1-cycle pulse: triangle outputs valid, start rasterising
//  draw_done      in   1             rasteriser finished current triangle; sampled only in S_WAIT_DRAW
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=S_IDLE; done=1; draw_en=0; all addresses, vertex regs, colour,
//   triangle index t, vertex index v = 0. Reset mid-run aborts immediately; no further draw_en.
//  Memory layout: vertex v occupies words 3v (x), 3v+1 (y), 3v+2 (z); addresses wrap mod 2^ADDR_WIDTH.
//  Topology: list -> triangle t uses vertices 3t,3t+1,3t+2. strip -> triangle t uses t,t+1,t+2;
//   after triangle 0, shift a<=b, b<=c and fetch only the new vertex into c (3 words, not 9).
//  FSM:
//   S_IDLE:      done=1. start=1 -> latch strip/count, t=0, v=0; count==0 -> stay S_IDLE (done stays 1),
//                else -> S_FETCH with words_needed=9.
//   S_FETCH:     one word address per cycle (3v+k), mem_col_addr=t on first fetch cycle; data captured the
//                cycle after its address into the next free a/b/c x/y/z slot. After last address -> S_DRAIN.
//   S_DRAIN:     capture final word (and colour if not yet captured) -> S_DRAW.
//   S_DRAW:      draw_en=1 for exactly one cycle; outputs a*,b*,c*,colour valid -> S_WAIT_DRAW.
//   S_WAIT_DRAW: outputs held stable. draw_done=1 -> t=t+1; t==count -> S_IDLE, else -> S_FETCH
//                (words_needed = strip ? 3 : 9, v advances by 1 (strip) or 3 (list)).
//  Latency per triangle: words_needed + 2 cycles before draw_en, plus rasteriser time.
//  done=0 from the cycle after an accepted start with count>0 until return to S_IDLE.
//  start while busy is ignored; strip/count changes mid-run have no effect.
//  draw_done outside S_WAIT_DRAW is ignored. draw_done in the cycle after draw_en is legal.
//  count is unsigned; t compared at full WIDTH.
// TESTING
//  1 list, count=2, verts 0..5 = (10v,20v,v) -> draw_en x2; tri0 a=(0,0,0) b=(10,20,1) c=(20,40,2);
//    tri1 a=(30,60,3); addresses 0..17 each read once; done rises after 2nd draw_done.
//  2 strip, count=3 -> tri2 = verts 2,3,4; mem_read_addr covers 0..14 only; 9+3+3 fetch cycles total.
//  3 count=0, start=1 -> done never drops, draw_en never asserted.
//  4 draw_done held 0 for 50 cycles -> a*/b*/c*/colour stable, no 2nd draw_en; then release -> next tri.
//  5 reset=0 during S_WAIT_DRAW of tri1 (count=4) -> next cycle done=1, draw_en=0; new start runs cleanly.
//  6 start pulsed while busy -> ignored; colour per tri = mem_col[t] (e.g. 3'b101 at t=1).

Source files
------------

// File: rtl/draw_triangle_pipe_if.sv
// Vertex/colour memory ports and triangle hand-off to the rasteriser.
// master = draw_triangle_pipe side, slave = memories plus rasteriser side.
interface draw_triangle_pipe_if #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int ADDR_WIDTH   = 8
);
  logic [ADDR_WIDTH-1:0]   mem_read_addr;
  logic [WIDTH-1:0]        mem_read_data;
  logic [ADDR_WIDTH-1:0]   mem_col_addr;
  logic [COLOUR_WIDTH-1:0] mem_col_data;
  logic [WIDTH-1:0]        ax, ay, az, bx, by, bz, cx, cy, cz;
  logic [COLOUR_WIDTH-1:0] colour;
  logic                    draw_en;
  logic                    draw_done;

  modport master (
    output mem_read_addr, mem_col_addr,
    input  mem_read_data, mem_col_data,
    output ax, ay, az, bx, by, bz, cx, cy, cz, colour, draw_en,
    input  draw_done
  );

  modport slave (
    input  mem_read_addr, mem_col_addr,
    output mem_read_data, mem_col_data,
    input  ax, ay, az, bx, by, bz, cx, cy, cz, colour, draw_en,
    output draw_done
  );
endinterface

// File: rtl/draw_triangle_pipe.sv
// Walks the screen-space vertex buffer, assembles strip/list triangles with a
// per-triangle colour and hands each one to the rasteriser.
module draw_triangle_pipe #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              strip,
  input  logic [WIDTH-1:0]  count,
  output logic              done,
  output logic [2:0]        fsm_state,
  draw_triangle_pipe_if.master bus
);

  // Handshake: draw_en is a one-cycle valid; the triangle outputs then stay
  // stable until draw_done (ready) is seen in S_WAIT_DRAW. draw_done in any
  // other state is ignored.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DRAIN     = 3'd2,
    S_DRAW      = 3'd3,
    S_WAIT_DRAW = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic                    strip_q;
  logic [WIDTH-1:0]        count_q;
  logic [WIDTH-1:0]        t;
  logic [WIDTH-1:0]        t_inc;
  logic [3:0]              words_needed;
  logic [3:0]              k;
  logic [3:0]              cap_slot;
  logic                    cap_valid;
  logic                    col_pending;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   next_ptr;
  logic [ADDR_WIDTH-1:0]   col_addr_q;
  logic [COLOUR_WIDTH-1:0] colour_q;
  logic [WIDTH-1:0]        verts [9];
  logic                    last_fetch;
  logic                    tri_last;

  assign t_inc      = t + WIDTH'(1);
  assign tri_last   = (t_inc == count_q);
  assign last_fetch = (k == (words_needed - 4'd1));

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    done        = 1'b0;
    bus.draw_en = 1'b0;
    case (state)
      S_IDLE: begin
        done = 1'b1;
        if (start && (count != '0)) state_next = S_FETCH;
      end
      S_FETCH:     if (last_fetch) state_next = S_DRAIN;
      S_DRAIN:     state_next = S_DRAW;
      S_DRAW: begin
        bus.draw_en = 1'b1;
        state_next  = S_WAIT_DRAW;
      end
      S_WAIT_DRAW: if (bus.draw_done) state_next = tri_last ? S_IDLE : S_FETCH;
      default:     state_next = S_IDLE;
    endcase
  end

  // Reads are contiguous for both topologies: a list triangle takes the next
  // 9 words, a strip triangle after the first takes the next 3 (one vertex).
  always_ff @(posedge clock) begin
    if (!reset) begin
      strip_q      <= 1'b0;
      count_q      <= '0;
      t            <= '0;
      words_needed <= 4'd9;
      k            <= 4'd0;
      cap_slot     <= 4'd0;
      cap_valid    <= 1'b0;
      col_pending  <= 1'b0;
      addr_q       <= '0;
      next_ptr     <= '0;
      col_addr_q   <= '0;
      colour_q     <= '0;
      for (int i = 0; i < 9; i++) verts[i] <= '0;
    end else begin
      cap_valid   <= (state == S_FETCH);
      cap_slot    <= ((words_needed == 4'd9) ? 4'd0 : 4'd6) + k;
      col_pending <= (state == S_FETCH) && (k == 4'd0);
      if (cap_valid)   verts[cap_slot] <= bus.mem_read_data;
      if (col_pending) colour_q        <= bus.mem_col_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            strip_q      <= strip;
            count_q      <= count;
            t            <= '0;
            k            <= 4'd0;
            words_needed <= 4'd9;
            addr_q       <= '0;
            col_addr_q   <= '0;
          end
        end
        S_FETCH: begin
          k <= k + 4'd1;
          if (last_fetch) next_ptr <= addr_q + ADDR_WIDTH'(1);
          else            addr_q   <= addr_q + ADDR_WIDTH'(1);
        end
        S_WAIT_DRAW: begin
          if (bus.draw_done) begin
            t            <= t_inc;
            k            <= 4'd0;
            words_needed <= strip_q ? 4'd3 : 4'd9;
            if (!tri_last) begin
              addr_q     <= next_ptr;
              col_addr_q <= t_inc[ADDR_WIDTH-1:0];
              if (strip_q) begin
                verts[0] <= verts[3];
                verts[1] <= verts[4];
                verts[2] <= verts[5];
                verts[3] <= verts[6];
                verts[4] <= verts[7];
                verts[5] <= verts[8];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state         = state;
  assign bus.mem_read_addr = addr_q;
  assign bus.mem_col_addr  = col_addr_q;
  assign bus.ax            = verts[0];
  assign bus.ay            = verts[1];
  assign bus.az            = verts[2];
  assign bus.bx            = verts[3];
  assign bus.by            = verts[4];
  assign bus.bz            = verts[5];
  assign bus.cx            = verts[6];
  assign bus.cy            = verts[7];
  assign bus.cz            = verts[8];
  assign bus.colour        = colour_q;

endmodule
